// File: rtl/lut_pkg.sv
// lut_pkg: shared state type and sizing helpers for the mux-tree LUT
package lut_pkg;
  typedef enum logic [1:0] {EMPTY, LOAD, ACTIVE} lut_state_t;
  localparam int LUT_MAX_K = 6;
  function automatic int lut_depth(input int k);
    return 1 << k;
  endfunction
endpackage

// File: rtl/lut_using_mux_tree_mux.sv
// mux: 2:1 leaf cell of the LUT selection tree
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/lut_using_mux_tree.sv
// lut_using_mux_tree: serially loaded K-input LUT read through a 2:1 mux tree
module lut_using_mux_tree
  import lut_pkg::*;
#(
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_bit,
  output logic         cfg_done,
  input  logic [K-1:0] in,
  output logic         out,
  output logic         out_valid
);
  localparam int D = lut_depth(K);
  lut_state_t state, nxt;
  logic [K-1:0] cnt;
  logic [D-1:0] tbl;
  logic [2*D-2:0] n;
  logic acc, last;
  always_comb begin
    cfg_ready = state == LOAD;
    acc = cfg_ready && cfg_valid && !cfg_start;
    last = acc && cnt == K'(D - 1);
    nxt = cfg_start ? LOAD : last ? ACTIVE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= EMPTY;
    else state <= nxt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      tbl <= '0;
      out <= 1'b0;
      out_valid <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= last;
      out_valid <= state == ACTIVE;
      if (state == ACTIVE) out <= n[2*D-2];
      if (cfg_start) cnt <= '0;
      else if (acc) begin
        tbl[cnt] <= cfg_bit;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  // n holds every tree level back to back: leaves first, root last
  assign n[D-1:0] = tbl;
  for (genvar j = 0; j < K; j++) begin : g_lvl
    localparam int B = 2 * D - ((2 * D) >> j);
    for (genvar i = 0; i < (D >> (j + 1)); i++) begin : g_node
      mux u_mux (
        .d0 (n[B+2*i]),
        .d1 (n[B+2*i+1]),
        .sel(in[j]),
        .y  (n[B+(D>>j)+i])
      );
    end
  end
endmodule

// File: tb/tb_lut_using_mux_tree.sv
// tb_lut_using_mux_tree: directed checks of K=1,2,3 LUTs against a behavioural model
module tb_lut_using_mux_tree;
  logic clk = 0;
  logic rst = 1;
  logic [2:0] start = '0, valid = '0, bitv = '0;
  logic [2:0] in_ [3];
  logic [2:0] rdy, dn, o, ov;
  int checks = 0, failures = 0;
  bit run = 0;
  int mst [3];
  int mcnt [3];
  bit [63:0] mtab [3];
  bit mout [3], mov [3], mdone [3];
  always #5 clk = ~clk;
  lut_using_mux_tree #(.K(1)) u1 (
    .clk(clk), .rst(rst), .cfg_start(start[0]), .cfg_valid(valid[0]), .cfg_ready(rdy[0]),
    .cfg_bit(bitv[0]), .cfg_done(dn[0]), .in(in_[0][0:0]), .out(o[0]), .out_valid(ov[0]));
  lut_using_mux_tree #(.K(2)) u2 (
    .clk(clk), .rst(rst), .cfg_start(start[1]), .cfg_valid(valid[1]), .cfg_ready(rdy[1]),
    .cfg_bit(bitv[1]), .cfg_done(dn[1]), .in(in_[1][1:0]), .out(o[1]), .out_valid(ov[1]));
  lut_using_mux_tree #(.K(3)) u3 (
    .clk(clk), .rst(rst), .cfg_start(start[2]), .cfg_valid(valid[2]), .cfg_ready(rdy[2]),
    .cfg_bit(bitv[2]), .cfg_done(dn[2]), .in(in_[2]), .out(o[2]), .out_valid(ov[2]));
  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask
  // model: 0 = no table, 1 = loading, 2 = table complete
  always @(posedge clk) begin
    int d;
    for (int u = 0; u < 3; u++) begin
      d = 2 << u;
      if (rst) begin
        mst[u] = 0; mcnt[u] = 0; mtab[u] = '0; mout[u] = 0; mov[u] = 0; mdone[u] = 0;
      end else begin
        mdone[u] = 0;
        mov[u] = mst[u] == 2;
        if (mst[u] == 2) mout[u] = mtab[u][int'(in_[u]) % d];
        if (start[u]) begin
          mst[u] = 1; mcnt[u] = 0;
        end else if (mst[u] == 1 && valid[u]) begin
          mtab[u][mcnt[u]] = bitv[u];
          mcnt[u]++;
          if (mcnt[u] == d) begin
            mst[u] = 2; mcnt[u] = 0; mdone[u] = 1;
          end
        end
      end
    end
  end
  always @(posedge clk) if (run) begin
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("model_ready%0d", u), rdy[u], mst[u] == 1);
      chk($sformatf("model_done%0d", u), dn[u], mdone[u]);
      chk($sformatf("model_out%0d", u), o[u], mout[u]);
      chk($sformatf("model_ov%0d", u), ov[u], mov[u]);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strt(input int u);
    start[u] = 1; cyc(1); start[u] = 0;
  endtask
  task automatic snd(input int u, input bit b, input int gap);
    cyc(gap); valid[u] = 1; bitv[u] = b; cyc(1); valid[u] = 0;
  endtask
  task automatic put(input int u, input int v);
    logic [2:0] t;
    t = v[2:0]; in_[u] = t; cyc(1);
  endtask
  initial begin
    logic [7:0] e;
    for (int u = 0; u < 3; u++) in_[u] = '0;
    cyc(1); run = 1; cyc(2);
    chk("rst_ready", rdy[1], 0); chk("rst_out", o[1], 0); chk("rst_ov", ov[1], 0); chk("rst_done", dn[1], 0);
    rst = 0;
    // K=1 inverter
    strt(0); chk("k1_ready", rdy[0], 1);
    snd(0, 1, 0); snd(0, 0, 0);
    chk("k1_done", dn[0], 1);
    put(0, 0); chk("k1_not0", o[0], 1); chk("k1_ov", ov[0], 1); chk("k1_done_once", dn[0], 0);
    put(0, 1); chk("k1_not1", o[0], 0);
    // K=2 AND with gaps
    strt(1);
    snd(1, 0, 0); snd(1, 0, 1); snd(1, 0, 2); snd(1, 1, 3);
    chk("k2_done", dn[1], 1);
    put(1, 0); chk("and0", o[1], 0);
    put(1, 1); chk("and1", o[1], 0);
    put(1, 2); chk("and2", o[1], 0);
    put(1, 3); chk("and3", o[1], 1);
    // K=3 restart with a colliding bit
    strt(2);
    for (int i = 0; i < 5; i++) snd(2, 1, 0);
    start[2] = 1; valid[2] = 1; bitv[2] = 1; cyc(1); start[2] = 0; valid[2] = 0;
    e = 8'hE8;
    for (int i = 0; i < 7; i++) snd(2, e[i], 0);
    chk("k3_no_early_done", dn[2], 0); chk("k3_still_ready", rdy[2], 1);
    snd(2, e[7], 0); chk("k3_done", dn[2], 1);
    put(2, 3); chk("maj011", o[2], 1);
    put(2, 4); chk("maj100", o[2], 0);
    put(2, 0); chk("maj000", o[2], 0);
    put(2, 7); chk("maj111", o[2], 1);
    // reset mid-load
    strt(1); snd(1, 1, 0); snd(1, 1, 0);
    rst = 1; cyc(1); rst = 0;
    chk("mid_rst_ready", rdy[1], 0); chk("mid_rst_out", o[1], 0); chk("mid_rst_ov", ov[1], 0);
    chk("mid_rst_out3", o[2], 0);
    strt(1); snd(1, 0, 0); snd(1, 1, 0); snd(1, 1, 0); snd(1, 0, 0);
    put(1, 0); chk("xor0", o[1], 0);
    put(1, 1); chk("xor1", o[1], 1);
    put(1, 2); chk("xor2", o[1], 1);
    put(1, 3); chk("xor3", o[1], 0);
    // reconfigure XOR -> NAND while active
    strt(1); chk("reload_ov_t", ov[1], 1);
    in_[1] = 3'd1; cyc(1);
    chk("reload_ov_drop", ov[1], 0); chk("reload_hold", o[1], 0);
    snd(1, 1, 0); snd(1, 1, 0); snd(1, 1, 0);
    chk("reload_hold2", o[1], 0);
    snd(1, 0, 1);
    chk("nand_done", dn[1], 1); chk("nand_ov_late", ov[1], 0);
    put(1, 3); chk("nand3", o[1], 0); chk("nand_ov", ov[1], 1);
    put(1, 0); chk("nand0", o[1], 1);
    // cfg_valid ignored in EMPTY and ACTIVE
    valid[2] = 1; bitv[2] = 1; valid[1] = 1; bitv[1] = 0;
    cyc(3);
    chk("empty_ready", rdy[2], 0); chk("empty_done", dn[2], 0); chk("active_ready", rdy[1], 0);
    valid[2] = 0; valid[1] = 0;
    put(1, 1); chk("nand1_kept", o[1], 1);
    put(1, 2); chk("nand2_kept", o[1], 1);
    chk("active_done", dn[1], 0);
    cyc(2);
    run = 0; cyc(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
